// File: rtl/scope_capture_pkg.sv
// Shared definitions for the scope capture block: FSM encoding, trigger
// mode codes and the width helpers used to size ports and counters.
package scope_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Mode 2'b11 is not decoded separately and therefore behaves as normal.
  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Two-bank sample store: 2*DEPTH words of all channels side by side. The
// bank bit is the address MSB so the writer and the display reader can
// work on different frames at the same time.
module capture_ram
  import scope_capture_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 24,
  localparam int AW = addr_width(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:2*DEPTH-1];

  // Write port: one word holds every channel of a single sample.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port: registered, one cycle of latency.
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered multi-channel capture with pre-trigger history and a
// double-buffered display frame.
//
// state | meaning
// IDLE  | waiting to start (arm pulse in single mode, immediate otherwise)
// PRE   | filling the pre-trigger history, detector off
// ARMED | writing samples and watching trig_ch for a crossing
// POST  | filling the remainder of the frame after the trigger
// DONE  | frame handed to the display bank, waiting to restart
module scope_capture
  import scope_capture_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 1024,
  parameter int PRETRIG      = 256,
  parameter int AUTO_TIMEOUT = 4096,
  localparam int CH_W   = ch_width(NUM_CH),
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [CH_W-1:0]          trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_rising,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     hold,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [2:0]               state,
  output logic                     frame_valid,
  output logic                     triggered
);

  // One down-counter is shared by PRE, ARMED and POST; size it for the longest run.
  localparam int CNT_MAX = (DEPTH > AUTO_TIMEOUT) ? DEPTH : AUTO_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int POST_N  = DEPTH - PRETRIG - 1;
  localparam logic [CNT_W-1:0]  PRE_LOAD  = CNT_W'((PRETRIG > 0) ? PRETRIG - 1 : 0);
  localparam logic [CNT_W-1:0]  AUTO_LOAD = CNT_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam state_t START_STATE = (PRETRIG == 0) ? S_ARMED : S_PRE;
  localparam logic [CNT_W-1:0]  START_LOAD = (PRETRIG == 0) ? AUTO_LOAD : PRE_LOAD;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        wr_ptr, trig_addr, origin, rd_idx;
  logic                     wr_bank, trig_flag;
  logic                     prev_valid, rd_valid;
  logic [DATA_W-1:0]        prev_data, cur_data;
  logic [CH_W-1:0]          trig_ch_q, rd_ch_q;
  logic                     accept, ch_changed, crossing, real_trig;
  logic                     fire, fire_real, enter_done;
  logic [NUM_CH*DATA_W-1:0] ram_q;

  assign state      = state_q;
  assign accept     = sample_en && (state_q inside {S_PRE, S_ARMED, S_POST});
  assign ch_changed = (trig_ch != trig_ch_q);
  assign rd_idx     = origin + rd_addr;

  // Select the trigger source sample; an out-of-range channel reads as 0.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (trig_ch == CH_W'(k)) cur_data = ch_data[k*DATA_W +: DATA_W];
  end

  // Edge detector; a channel switch in this very cycle also blocks the compare.
  always_comb begin
    if (trig_rising) crossing = (prev_data <  trig_level) && (cur_data >= trig_level);
    else             crossing = (prev_data >= trig_level) && (cur_data <  trig_level);
    real_trig = prev_valid && !ch_changed && crossing;
  end

  // Next-state, counter and trigger/frame-completion events.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire       = 1'b0;
    fire_real  = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode != MODE_SINGLE || arm) begin
          state_d = START_STATE;
          cnt_d   = START_LOAD;
        end
      end
      S_PRE: begin
        if (sample_en) begin
          if (cnt_q == '0) begin
            state_d = S_ARMED;
            cnt_d   = AUTO_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (sample_en) begin
          if (real_trig) begin
            fire      = 1'b1;
            fire_real = 1'b1;
          end else if (mode == MODE_AUTO && cnt_q == '0) begin
            fire = 1'b1;
          end
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (fire) begin
            if (POST_N == 0) begin
              state_d    = S_DONE;
              enter_done = 1'b1;
            end else begin
              state_d = S_POST;
              cnt_d   = POST_LOAD;
            end
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          if (cnt_q == '0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!hold && (mode != MODE_SINGLE || arm)) begin
          state_d = START_STATE;
          cnt_d   = START_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and trigger-history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr     <= '0;
      prev_data  <= '0;
      prev_valid <= 1'b0;
      trig_ch_q  <= '0;
      trig_addr  <= '0;
      trig_flag  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trig_ch_q <= trig_ch;
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prev_data <= cur_data;
      end
      if ((state_d == S_PRE && state_q != S_PRE) || ch_changed) prev_valid <= 1'b0;
      else if (accept)                                           prev_valid <= 1'b1;
      if (fire) begin
        trig_addr <= wr_ptr;
        trig_flag <= fire_real;
      end
    end
  end

  // Frame hand-off: swap banks and record where the new display frame starts.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      origin      <= '0;
      frame_valid <= 1'b0;
      triggered   <= 1'b0;
    end else if (enter_done) begin
      wr_bank     <= ~wr_bank;
      origin      <= ((state_q == S_ARMED) ? wr_ptr : trig_addr) - PRE_OFS;
      frame_valid <= 1'b1;
      triggered   <= (state_q == S_ARMED) ? fire_real : trig_flag;
    end
  end

  // Read-side pipeline tracking; rd_valid forces rd_data to 0 right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_ch_q  <= '0;
    end else begin
      rd_valid <= 1'b1;
      rd_ch_q  <= rd_ch;
    end
  end

  // Channel select on the registered RAM word.
  always_comb begin
    rd_data = '0;
    if (rd_valid)
      for (int k = 0; k < NUM_CH; k++)
        if (rd_ch_q == CH_W'(k)) rd_data = ram_q[k*DATA_W +: DATA_W];
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_CH*DATA_W)
  ) u_ram (
    .clock   (clock),
    .we      (accept),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (ch_data),
    .rd_addr ({~wr_bank, rd_idx}),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture (NUM_CH=2, DATA_W=12, DEPTH=16,
// PRETRIG=4, AUTO_TIMEOUT=32). Stimulus pushes expected values; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_scope_capture;

   localparam int SEL_STATE = 0;
   localparam int SEL_RD    = 1;
   localparam int SEL_FV    = 2;
   localparam int SEL_TRIG  = 3;

   typedef struct {
      string name;
      int    sel;
      int    exp;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sample_en = 1'b0;
   logic [23:0] ch_data = '0;
   logic [0:0]  trig_ch = '0;
   logic [11:0] trig_level = 12'd10;
   logic        trig_rising = 1'b1;
   logic [1:0]  mode = 2'b01;
   logic        arm = 1'b0;
   logic        hold = 1'b0;
   logic [0:0]  rd_ch = '0;
   logic [3:0]  rd_addr = '0;
   logic [11:0] rd_data;
   logic [2:0]  state;
   logic        frame_valid;
   logic        triggered;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   scope_capture #(
      .NUM_CH       (2),
      .DATA_W       (12),
      .DEPTH        (16),
      .PRETRIG      (4),
      .AUTO_TIMEOUT (32)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sample_en   (sample_en),
      .ch_data     (ch_data),
      .trig_ch     (trig_ch),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .mode        (mode),
      .arm         (arm),
      .hold        (hold),
      .rd_ch       (rd_ch),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .state       (state),
      .frame_valid (frame_valid),
      .triggered   (triggered)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Monitor: drain every expectation queued since the last rising edge.
   initial begin
      exp_t e;
      int   act;
      bit   ok;
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
               SEL_STATE: begin
                  act = int'(state);
                  ok  = (int'(state) == e.exp);
               end
               SEL_RD: begin
                  act = int'(rd_data);
                  ok  = (int'(rd_data) == e.exp);
               end
               SEL_FV: begin
                  act = int'(frame_valid);
                  ok  = (int'(frame_valid) == e.exp);
               end
               default: begin
                  act = int'(triggered);
                  ok  = (int'(triggered) == e.exp);
               end
            endcase
            n_checks++;
            if (!ok) begin
               n_errors++;
               $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_val(input string name, input int sel, input int val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = val;
      exp_q.push_back(e);
   endtask

   task automatic put(input int d0, input int d1, input int gap);
      ch_data   = {12'(d1), 12'(d0)};
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic do_reset(input logic [1:0] m);
      reset     = 1'b1;
      mode      = m;
      arm       = 1'b0;
      hold      = 1'b0;
      sample_en = 1'b0;
      trig_ch   = '0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic read_chk(input string name, input int ch, input int addr, input int val);
      logic [3:0] a;
      logic       c;
      a = 4'(addr);
      c = 1'(ch);
      rd_ch   = c;
      rd_addr = a;
      tick();
      expect_val(name, SEL_RD, val);
   endtask

   initial begin
      // Normal mode, rising ramp on ch0 through level 10.
      do_reset(2'b01);
      expect_val("rst_state", SEL_STATE, 0);
      expect_val("rst_fv", SEL_FV, 0);
      expect_val("rst_trig", SEL_TRIG, 0);
      expect_val("rst_rd", SEL_RD, 0);
      tick();
      expect_val("t1_pre", SEL_STATE, 1);
      for (int i = 0; i < 22; i++) put(i, 100 + i, 0);
      expect_val("t1_done", SEL_STATE, 4);
      expect_val("t1_fv", SEL_FV, 1);
      expect_val("t1_trig", SEL_TRIG, 1);
      tick();
      expect_val("t1_restart", SEL_STATE, 1);
      read_chk("t1_rd0", 0, 0, 6);
      read_chk("t1_rd4", 0, 4, 10);
      read_chk("t1_rd15", 0, 15, 21);
      read_chk("t1_ch1_rd4", 1, 4, 110);

      // Reset in the middle of POST.
      for (int i = 0; i < 13; i++) put(i, 0, 0);
      expect_val("t2_post", SEL_STATE, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_val("t2_rst_state", SEL_STATE, 0);
      expect_val("t2_rst_fv", SEL_FV, 0);
      expect_val("t2_rst_rd", SEL_RD, 0);
      expect_val("t2_rst_trig", SEL_TRIG, 0);

      // Auto mode, flat input: forced trigger on the 36th sample.
      do_reset(2'b00);
      tick();
      for (int i = 0; i < 35; i++) put(0, 0, 0);
      expect_val("t3_armed_35", SEL_STATE, 2);
      put(0, 0, 0);
      expect_val("t3_forced", SEL_STATE, 3);
      expect_val("t3_fv_pending", SEL_FV, 0);
      for (int i = 0; i < 11; i++) put(0, 0, 0);
      expect_val("t3_done", SEL_STATE, 4);
      expect_val("t3_fv", SEL_FV, 1);
      expect_val("t3_trig", SEL_TRIG, 0);

      // Single mode: waits for arm, freezes after DONE until the next arm.
      do_reset(2'b10);
      tick();
      expect_val("t4_idle", SEL_STATE, 0);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      expect_val("t4_arm", SEL_STATE, 1);
      for (int i = 0; i < 22; i++) put(i, 0, 0);
      expect_val("t4_done", SEL_STATE, 4);
      expect_val("t4_trig", SEL_TRIG, 1);
      for (int i = 0; i < 22; i++) put(100 + i, 0, 0);
      expect_val("t4_stays", SEL_STATE, 4);
      read_chk("t4_rd0", 0, 0, 6);
      read_chk("t4_rd4", 0, 4, 10);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      expect_val("t4_rearm", SEL_STATE, 1);

      // Normal mode with hold across DONE.
      do_reset(2'b01);
      hold = 1'b1;
      tick();
      for (int i = 0; i < 22; i++) put(i, 0, 0);
      expect_val("t5_done", SEL_STATE, 4);
      read_chk("t5_rd_a", 0, 4, 10);
      put(55, 0, 0);
      expect_val("t5_held", SEL_STATE, 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_val("t5_rd_stable", SEL_RD, 10);
         expect_val("t5_state_stable", SEL_STATE, 4);
      end
      hold = 1'b0;
      tick();
      expect_val("t5_release", SEL_STATE, 1);

      // Falling edge on ch1, source switched while ARMED, sparse samples.
      do_reset(2'b01);
      trig_level  = 12'd50;
      trig_rising = 1'b0;
      tick();
      for (int k = 0; k < 6; k++) put(200, 20, 3);
      expect_val("t6_armed_ch0", SEL_STATE, 2);
      trig_ch = 1'b1;
      tick();
      put(200, 20, 3);
      expect_val("t6_first_ch1", SEL_STATE, 2);
      put(200, 60, 3);
      put(200, 80, 3);
      put(200, 70, 3);
      expect_val("t6_before_cross", SEL_STATE, 2);
      put(200, 40, 3);
      expect_val("t6_cross", SEL_STATE, 3);
      for (int k = 11; k < 21; k++) put(200, 40, 3);
      put(200, 40, 0);
      expect_val("t6_done", SEL_STATE, 4);
      expect_val("t6_trig", SEL_TRIG, 1);
      read_chk("t6_ch1_rd4", 1, 4, 40);
      read_chk("t6_ch1_rd3", 1, 3, 70);
      read_chk("t6_ch1_rd2", 1, 2, 80);
      read_chk("t6_ch0_rd0", 0, 0, 200);

      tick();
      tick();
      if (n_errors != 0 || n_checks < 12)
         $display("FAIL summary: got %0d errors in %0d checks expected 0 errors", n_errors, n_checks);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
